// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
//
// Contents:
//   fetch_state_t     fetch FSM state encoding (ST_FAULT only exists when
//                     FETCH_MISALIGN_TRAP_EN is defined)
//   INSTR_BYTES       size of one instruction word in bytes
//   DEFAULT_RESET_PC  default value of the RESET_PC parameter
//   next_seq_pc()     sequential PC step, wraps modulo 2^32

package fetch_pkg;

  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    ST_FAULT = 2'd3
`endif
  } fetch_state_t;

  // 32-bit add drops the carry, so 0xFFFF_FFFC steps to 0x0000_0000.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter register with sequential/redirect next-PC mux
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset, loads RESET_PC
//   load_target  load target into pc (takes priority over load_seq)
//   load_seq     advance pc by one instruction
//   target       redirect address
//   pc           current program counter
//   pc_next      value pc takes at the next clock edge

module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_target,
  input  logic        load_seq,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic [31:0] pc_next
);

  always_comb begin
    pc_next = pc;
    if (load_target) begin
      pc_next = target;
    end else if (load_seq) begin
      pc_next = next_seq_pc(pc);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch unit with branch redirect
//
// Build option: FETCH_MISALIGN_TRAP_EN - a redirect to a non word-aligned
// target sets misalign_fault and parks the unit in ST_FAULT until reset.
// Without it the low two target bits are cleared and misalign_fault is 0.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   take_branch     redirect request, branch_target valid with it
//   branch_target   redirect PC
//   imem_req        instruction memory request (held until imem_ack)
//   imem_addr       fetch address (held until imem_ack)
//   imem_ack        memory response, imem_rdata valid in the same cycle
//   imem_rdata      fetched instruction word
//   instr_valid     instr/instr_pc valid toward decode
//   instr_ready     decode accepts the held instruction
//   instr, instr_pc held instruction and its PC
//   misalign_fault  sticky misaligned-target flag

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        take_branch,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        misalign_fault
);

  fetch_state_t state;
  logic         kill;         // in-flight request belongs to a squashed path
  logic [31:0]  pc;
  logic [31:0]  pc_next;
  logic [31:0]  target;
  logic         bad_target;
  logic         load_target;
  logic         load_seq;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target     = branch_target;
  assign bad_target = take_branch && (branch_target[1:0] != 2'b00);
`else
  assign target     = branch_target & ~32'h0000_0003;
  assign bad_target = 1'b0;
`endif

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .load_target (load_target),
    .load_seq    (load_seq),
    .target      (target),
    .pc          (pc),
    .pc_next     (pc_next)
  );

  // The PC tracks the architectural path; it may run ahead of imem_addr
  // while a squashed request is still waiting for its ack.
  always_comb begin
    load_target = 1'b0;
    load_seq    = 1'b0;
    if (!bad_target) begin
      case (state)
        ST_IDLE, ST_WAIT: load_target = take_branch;
        ST_HOLD: begin
          load_target = take_branch;
          load_seq    = instr_ready && !take_branch;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      kill        <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_fault <= 1'b0;
    end else if (bad_target && (state != ST_FAULT)) begin
      state          <= ST_FAULT;
      kill           <= 1'b0;
      imem_req       <= 1'b0;
      instr_valid    <= 1'b0;
      misalign_fault <= 1'b1;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          state     <= ST_WAIT;
          imem_req  <= 1'b1;
          imem_addr <= pc_next;
        end
        ST_WAIT: begin
          if (imem_ack) begin
            if (kill || take_branch) begin
              // Stale response: drop it and reissue on the current path.
              kill      <= 1'b0;
              imem_addr <= pc_next;
            end else begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              imem_req    <= 1'b0;
              instr_valid <= 1'b1;
              state       <= ST_HOLD;
            end
          end else if (take_branch) begin
            kill <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (take_branch || instr_ready) begin
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            imem_addr   <= pc_next;
            state       <= ST_WAIT;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        ST_FAULT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
`endif
        default: begin
          state    <= ST_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifndef FETCH_MISALIGN_TRAP_EN
  assign misalign_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit

module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        take_branch;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign_fault;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [31:0] MEM_XOR = 32'h5A5A_A5A5;

  fetch_unit #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .take_branch    (take_branch),
    .branch_target  (branch_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .misalign_fault (misalign_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns a word derived from the requested address.
  assign imem_rdata = imem_addr ^ MEM_XOR;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects a request for addr now, the ack is taken at the next edge.
  task automatic fetch_one(input logic [31:0] addr);
    check("wait_req", {31'h0, imem_req}, 32'h1);
    check("wait_addr", imem_addr, addr);
    check("wait_valid", {31'h0, instr_valid}, 32'h0);
    tick();
    check("hold_valid", {31'h0, instr_valid}, 32'h1);
    check("hold_pc", instr_pc, addr);
    check("hold_instr", instr, addr ^ MEM_XOR);
    check("hold_req", {31'h0, imem_req}, 32'h0);
  endtask

  initial begin
    rst           = 1'b1;
    take_branch   = 1'b0;
    branch_target = 32'h0;
    imem_ack      = 1'b1;
    instr_ready   = 1'b1;
    tick();
    tick();
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_fault", {31'h0, misalign_fault}, 32'h0);

    // Sequential stream, ack always high.
    rst = 1'b0;
    check("idle_req", {31'h0, imem_req}, 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      fetch_one(32'(i) * 32'd4);
      if (i < 4) tick();
    end

    // Stall in HOLD at 0x10.
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", {31'h0, instr_valid}, 32'h1);
      check("stall_pc", instr_pc, 32'h10);
      check("stall_instr", instr, 32'h10 ^ MEM_XOR);
      check("stall_req", {31'h0, imem_req}, 32'h0);
    end
    instr_ready = 1'b1;
    tick();
    fetch_one(32'h14);

    // Redirect in WAIT with the ack two cycles late.
    imem_ack = 1'b0;
    tick();
    check("kill_addr0", imem_addr, 32'h18);
    take_branch   = 1'b1;
    branch_target = 32'h100;
    instr_ready   = 1'b0;
    tick();
    take_branch = 1'b0;
    check("kill_addr1", imem_addr, 32'h18);
    check("kill_req1", {31'h0, imem_req}, 32'h1);
    tick();
    check("kill_addr2", imem_addr, 32'h18);
    imem_ack = 1'b1;
    tick();
    check("kill_drop_valid", {31'h0, instr_valid}, 32'h0);
    fetch_one(32'h100);

    // Redirect from HOLD drops the held instruction.
    take_branch   = 1'b1;
    branch_target = 32'h20;
    tick();
    take_branch = 1'b0;
    check("hold_br_valid", {31'h0, instr_valid}, 32'h0);
    fetch_one(32'h20);

    // Redirect beats instr_ready in the same HOLD cycle.
    take_branch   = 1'b1;
    branch_target = 32'h40;
    instr_ready   = 1'b1;
    tick();
    take_branch = 1'b0;
    fetch_one(32'h40);

    // PC wrap at the top of the address space.
    take_branch   = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    tick();
    take_branch = 1'b0;
    fetch_one(32'hFFFF_FFFC);
    tick();
    fetch_one(32'h0000_0000);

    // Branch coincident with ack in WAIT discards the response.
    tick();
    check("coinc_addr0", imem_addr, 32'h4);
    take_branch   = 1'b1;
    branch_target = 32'h200;
    tick();
    take_branch = 1'b0;
    check("coinc_valid", {31'h0, instr_valid}, 32'h0);
    fetch_one(32'h200);

    // Asynchronous reset mid-request, ack still pending, branch in IDLE.
    imem_ack = 1'b0;
    tick();
    check("pre_rst_addr", imem_addr, 32'h204);
    #2;
    rst = 1'b1;
    #1;
    check("async_req", {31'h0, imem_req}, 32'h0);
    check("async_valid", {31'h0, instr_valid}, 32'h0);
    check("async_instr", instr, 32'h0);
    check("async_pc", instr_pc, 32'h0);
    imem_ack      = 1'b1;
    take_branch   = 1'b1;
    branch_target = 32'h300;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("idle2_req", {31'h0, imem_req}, 32'h0);
    tick();
    take_branch = 1'b0;
    fetch_one(32'h300);

    // Misaligned redirect target.
    take_branch   = 1'b1;
    branch_target = 32'h102;
    tick();
    take_branch = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_fault", {31'h0, misalign_fault}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      check("mis_req", {31'h0, imem_req}, 32'h0);
      check("mis_valid", {31'h0, instr_valid}, 32'h0);
      tick();
    end
`else
    check("mis_fault", {31'h0, misalign_fault}, 32'h0);
    fetch_one(32'h100);
`endif

    rst = 1'b1;
    tick();
    check("final_fault", {31'h0, misalign_fault}, 32'h0);
    check("final_req", {31'h0, imem_req}, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
